// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: FSM state encoding, R/W bit values and the
// default OV5640 device address. Used by sccb_responder and sccb_controller.
package sccb_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_SUB_HI,
        ST_SUB_HI_ACK,
        ST_SUB_LO,
        ST_SUB_LO_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } sccb_state_t;

    localparam logic SCCB_WR_BIT = 1'b0;
    localparam logic SCCB_RD_BIT = 1'b1;

    localparam logic [7:0] SCCB_OV5640_ADDR = 8'h78;

endpackage

// File: rtl/sccb_line_sync.sv
// Two-flop synchronizers and edge detection for SCL and SDA, plus
// START (SDA fall, SCL high) and STOP (SDA rise, SCL high) detection.
module sccb_line_sync (
    input  logic clk,
    input  logic rest,
    input  logic scl_pin,
    input  logic sda_pin,
    output logic sda_level,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;

    // Synchronize both lines and keep one cycle of history; idle bus is high
    always_ff @(posedge clk) begin
        if (rest) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_pin};
            sda_sync <= {sda_sync[0], sda_pin};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign sda_level = sda_sync[1];
    assign scl_rise  = scl_sync[1] & ~scl_prev;
    assign scl_fall  = ~scl_sync[1] & scl_prev;
    assign start     = scl_sync[1] & scl_prev & sda_prev & ~sda_sync[1];
    assign stop      = scl_sync[1] & scl_prev & ~sda_prev & sda_sync[1];

endmodule

// File: rtl/sccb_responder.sv
// SCCB target endpoint turning 3-phase writes and 2-phase reads into register-bus strobes.
// Optional build macro SCCB_RESP_AUTO_INC_EN enables sub-address auto-increment for bursts.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEVICE_ADDR    = SCCB_OV5640_ADDR,
    parameter int         SUB_ADDR_WIDTH = 16,
    parameter int         HOLD_CYC       = 8
) (
    input  logic                      clk,
    input  logic                      rest,
    input  logic                      sccb_scl,
    inout  wire                       sccb_sda,
    output logic [SUB_ADDR_WIDTH-1:0] reg_addr,
    output logic [7:0]                reg_wdata,
    output logic                      reg_we,
    output logic                      reg_re,
    input  logic [7:0]                reg_rdata,
    output logic                      busy
);

`ifdef SCCB_RESP_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    localparam logic [7:0] WR_ADDR = {DEVICE_ADDR[7:1], SCCB_WR_BIT};
    localparam logic [7:0] RD_ADDR = {DEVICE_ADDR[7:1], SCCB_RD_BIT};
    localparam logic [7:0] HOLD_LD = 8'(HOLD_CYC);
    localparam logic [SUB_ADDR_WIDTH-1:0] ADDR_ONE =
        {{(SUB_ADDR_WIDTH-1){1'b0}}, 1'b1};

    sccb_state_t state;
    logic [3:0]  bit_cnt;
    logic [6:0]  rx;
    logic [7:0]  tx;
    logic [7:0]  byte_in;
    logic        last_bit;
    logic        rd_mode;
    logic        re_d;
    logic        wr_seen;
    logic        sda_oe;
    logic        drive_val;
    logic [7:0]  hold_cnt;
    logic        hold_run;

    logic sda_level;
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;

    sccb_line_sync u_sync (
        .clk       (clk),
        .rest      (rest),
        .scl_pin   (sccb_scl),
        .sda_pin   (sccb_sda),
        .sda_level (sda_level),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start     (start),
        .stop      (stop)
    );

    // Open-drain: only ever pull low
    assign sccb_sda = sda_oe ? 1'b0 : 1'bz;

    assign byte_in  = {rx, sda_level};
    assign last_bit = (bit_cnt == 4'd7);

    // SDA level to present once the post-fall hold time has elapsed
    always_comb begin
        drive_val = 1'b0;
        case (state)
            ST_DEV_ACK,
            ST_SUB_HI_ACK,
            ST_SUB_LO_ACK,
            ST_WDATA_ACK: drive_val = 1'b1;
            ST_RDATA:     drive_val = ~tx[7];
            default:      drive_val = 1'b0;
        endcase
    end

    // Protocol FSM, shifters, hold timer and register-bus strobes
    always_ff @(posedge clk) begin
        if (rest) begin
            state     <= ST_IDLE;
            bit_cnt   <= 4'd0;
            rx        <= 7'd0;
            tx        <= 8'd0;
            rd_mode   <= 1'b0;
            re_d      <= 1'b0;
            wr_seen   <= 1'b0;
            sda_oe    <= 1'b0;
            hold_cnt  <= 8'd0;
            hold_run  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            reg_re <= 1'b0;
            re_d   <= reg_re;
            if (re_d)
                tx <= reg_rdata;

            if (scl_fall) begin
                hold_cnt <= HOLD_LD;
                hold_run <= 1'b1;
            end else if (hold_run) begin
                if (hold_cnt <= 8'd1) begin
                    hold_run <= 1'b0;
                    sda_oe   <= drive_val;
                    if (state == ST_WDATA_ACK) begin
                        reg_we  <= 1'b1;
                        wr_seen <= 1'b1;
                    end
                end else begin
                    hold_cnt <= hold_cnt - 8'd1;
                end
            end

            if (start) begin
                state    <= ST_DEV_ADDR;
                bit_cnt  <= 4'd0;
                busy     <= 1'b1;
                sda_oe   <= 1'b0;
                hold_run <= 1'b0;
                wr_seen  <= 1'b0;
                reg_we   <= 1'b0;
            end else if (stop) begin
                state    <= ST_IDLE;
                busy     <= 1'b0;
                sda_oe   <= 1'b0;
                hold_run <= 1'b0;
                reg_we   <= 1'b0;
            end else if (scl_rise) begin
                rx      <= byte_in[6:0];
                bit_cnt <= bit_cnt + 4'd1;
                case (state)
                    ST_DEV_ADDR: begin
                        if (last_bit) begin
                            if (byte_in == WR_ADDR) begin
                                state   <= ST_DEV_ACK;
                                rd_mode <= 1'b0;
                            end else if (byte_in == RD_ADDR) begin
                                state   <= ST_DEV_ACK;
                                rd_mode <= 1'b1;
                                reg_re  <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_DEV_ACK: begin
                        bit_cnt <= 4'd0;
                        if (rd_mode)
                            state <= ST_RDATA;
                        else if (SUB_ADDR_WIDTH == 16)
                            state <= ST_SUB_HI;
                        else
                            state <= ST_SUB_LO;
                    end
                    ST_SUB_HI: begin
                        if (last_bit) begin
                            reg_addr[SUB_ADDR_WIDTH-1 -: 8] <= byte_in;
                            state <= ST_SUB_HI_ACK;
                        end
                    end
                    ST_SUB_HI_ACK: begin
                        bit_cnt <= 4'd0;
                        state   <= ST_SUB_LO;
                    end
                    ST_SUB_LO: begin
                        if (last_bit) begin
                            reg_addr[7:0] <= byte_in;
                            state <= ST_SUB_LO_ACK;
                        end
                    end
                    ST_SUB_LO_ACK: begin
                        bit_cnt <= 4'd0;
                        state   <= ST_WDATA;
                    end
                    ST_WDATA: begin
                        if (last_bit) begin
                            reg_wdata <= byte_in;
                            if (AUTO_INC && wr_seen)
                                reg_addr <= reg_addr + ADDR_ONE;
                            state <= ST_WDATA_ACK;
                        end
                    end
                    ST_WDATA_ACK: begin
                        bit_cnt <= 4'd0;
                        state   <= AUTO_INC ? ST_WDATA : ST_IGNORE;
                    end
                    ST_RDATA: begin
                        tx <= {tx[6:0], 1'b0};
                        if (last_bit)
                            state <= ST_RDATA_ACK;
                    end
                    ST_RDATA_ACK: begin
                        bit_cnt <= 4'd0;
                        if (AUTO_INC && !sda_level) begin
                            reg_addr <= reg_addr + ADDR_ONE;
                            reg_re   <= 1'b1;
                            state    <= ST_RDATA;
                        end else begin
                            state <= ST_IGNORE;
                        end
                    end
                    default: begin
                        bit_cnt <= 4'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sccb_responder.sv
// Self-checking bench for sccb_responder: bit-banged SCCB master plus a
// scoreboard of expected register-bus strobes.
`timescale 1ns/1ps
module tb_sccb_responder;

    localparam int Q = 100;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    logic [7:0]  reg_rdata = 8'h00;
    wire         sda_bus;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic        busy;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    sccb_responder dut (
        .clk       (clk),
        .rest      (rest),
        .sccb_scl  (scl),
        .sccb_sda  (sda_bus),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   nd_viol = 0;
    bit   watch_nd = 1'b0;
    logic ack;
    logic [7:0] d;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit we, input logic [15:0] a,
                            input logic [7:0] dat);
        exp_t e;
        e.we = we;
        e.addr = a;
        e.data = dat;
        sb.push_back(e);
    endtask

    // Pop and compare one expectation per observed strobe
    always @(negedge clk) begin
        if (reg_we || reg_re) begin
            chk("we_re_excl", {31'd0, reg_we & reg_re}, 0);
            if (sb.size() == 0) begin
                chk("sb_unexp", {30'd0, reg_we, reg_re}, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_kind", {31'd0, reg_we}, {31'd0, mon_e.we});
                chk("sb_addr", {16'd0, reg_addr}, {16'd0, mon_e.addr});
                if (mon_e.we)
                    chk("sb_wdata", {24'd0, reg_wdata}, {24'd0, mon_e.data});
            end
        end
        if (watch_nd && !m_low && sda_bus === 1'b0)
            nd_viol++;
    end

    task automatic bit_w(input logic b);
        #(Q) m_low = ~b;
        #(Q) scl = 1'b1;
        #(Q);
        #(Q) scl = 1'b0;
    endtask

    task automatic bit_r(output logic b);
        #(Q) m_low = 1'b0;
        #(Q) scl = 1'b1;
        #(Q) b = sda_bus;
        #(Q) scl = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] v, output logic a);
        for (int i = 7; i >= 0; i--)
            bit_w(v[i]);
        bit_r(a);
    endtask

    task automatic rd_byte(output logic [7:0] v, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            v[i] = b;
        end
        bit_w(nack);
    endtask

    task automatic start_c();
        if (scl) begin
            #(Q) m_low = 1'b1;
            #(Q) scl = 1'b0;
        end else begin
            #(Q) m_low = 1'b0;
            #(Q) scl = 1'b1;
            #(Q) m_low = 1'b1;
            #(Q) scl = 1'b0;
        end
    endtask

    task automatic stop_c();
        #(Q) m_low = 1'b1;
        #(Q) scl = 1'b1;
        #(Q) m_low = 1'b0;
        #(Q);
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: time %0t over limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("rst_addr", {16'd0, reg_addr}, 0);
        chk("rst_wdata", {24'd0, reg_wdata}, 0);
        chk("rst_we", {31'd0, reg_we}, 0);
        chk("rst_re", {31'd0, reg_re}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_sda", {31'd0, sda_bus}, 1);
        rest = 1'b0;
        settle();

        // 3-phase write 0x3008 = 0x42
        start_c();
        wr_byte(8'h78, ack); chk("t1_ack_dev", {31'd0, ack}, 0);
        @(negedge clk); chk("t1_busy", {31'd0, busy}, 1);
        wr_byte(8'h30, ack); chk("t1_ack_hi", {31'd0, ack}, 0);
        wr_byte(8'h08, ack); chk("t1_ack_lo", {31'd0, ack}, 0);
        push_exp(1'b1, 16'h3008, 8'h42);
        wr_byte(8'h42, ack); chk("t1_ack_dat", {31'd0, ack}, 0);
        stop_c();
        settle();
        chk("t1_drain", sb.size(), 0);
        chk("t1_addr_kept", {16'd0, reg_addr}, 32'h3008);
        chk("t1_busy_off", {31'd0, busy}, 0);

        // 2-phase write then 2-phase read of 0x300E
        start_c();
        wr_byte(8'h78, ack); chk("t2_ack_dev", {31'd0, ack}, 0);
        wr_byte(8'h30, ack); chk("t2_ack_hi", {31'd0, ack}, 0);
        wr_byte(8'h0E, ack); chk("t2_ack_lo", {31'd0, ack}, 0);
        stop_c();
        settle();
        reg_rdata = 8'h56;
        start_c();
        push_exp(1'b0, 16'h300E, 8'h00);
        wr_byte(8'h79, ack); chk("t2_ack_rd", {31'd0, ack}, 0);
        rd_byte(d, 1'b1);
        chk("t2_rdata", {24'd0, d}, 32'h56);
        @(negedge clk); chk("t2_busy", {31'd0, busy}, 1);
        stop_c();
        settle();
        chk("t2_busy_off", {31'd0, busy}, 0);
        chk("t2_drain", sb.size(), 0);

        // Foreign device address is ignored
        nd_viol = 0;
        watch_nd = 1'b1;
        start_c();
        wr_byte(8'h3C, ack); chk("t3_nack_dev", {31'd0, ack}, 1);
        wr_byte(8'h30, ack); chk("t3_nack_b1", {31'd0, ack}, 1);
        wr_byte(8'h08, ack); chk("t3_nack_b2", {31'd0, ack}, 1);
        stop_c();
        watch_nd = 1'b0;
        settle();
        chk("t3_no_drive", nd_viol, 0);
        chk("t3_drain", sb.size(), 0);

        // Reset in the middle of a data byte, then a full write
        start_c();
        wr_byte(8'h78, ack); chk("t4_ack_dev", {31'd0, ack}, 0);
        wr_byte(8'h30, ack);
        wr_byte(8'h08, ack);
        bit_w(1'b1);
        bit_w(1'b1);
        #(Q) m_low = 1'b0;
        #(Q) scl = 1'b1;
        @(negedge clk) rest = 1'b1;
        repeat (3) @(negedge clk);
        rest = 1'b0;
        @(negedge clk);
        chk("t4_sda_rel", {31'd0, sda_bus}, 1);
        chk("t4_busy", {31'd0, busy}, 0);
        chk("t4_addr_rst", {16'd0, reg_addr}, 0);
        #(Q) scl = 1'b0;
        stop_c();
        settle();
        start_c();
        wr_byte(8'h78, ack); chk("t4_ack_dev2", {31'd0, ack}, 0);
        wr_byte(8'h31, ack); chk("t4_ack_hi", {31'd0, ack}, 0);
        wr_byte(8'h00, ack); chk("t4_ack_lo", {31'd0, ack}, 0);
        push_exp(1'b1, 16'h3100, 8'h11);
        wr_byte(8'h11, ack); chk("t4_ack_dat", {31'd0, ack}, 0);
        stop_c();
        settle();
        chk("t4_drain", sb.size(), 0);

        // Repeated START after the sub-address, then a read
        reg_rdata = 8'h9C;
        start_c();
        wr_byte(8'h78, ack);
        wr_byte(8'h30, ack);
        wr_byte(8'h08, ack); chk("t5_ack_lo", {31'd0, ack}, 0);
        start_c();
        push_exp(1'b0, 16'h3008, 8'h00);
        wr_byte(8'h79, ack); chk("t5_ack_rd", {31'd0, ack}, 0);
        rd_byte(d, 1'b1);
        chk("t5_rdata", {24'd0, d}, 32'h9C);
        stop_c();
        settle();
        chk("t5_drain", sb.size(), 0);

        // Burst write at the top of the address space
        start_c();
        wr_byte(8'h78, ack);
        wr_byte(8'hFF, ack);
        wr_byte(8'hFF, ack); chk("t6_ack_lo", {31'd0, ack}, 0);
        push_exp(1'b1, 16'hFFFF, 8'hAA);
        wr_byte(8'hAA, ack); chk("t6_ack_d0", {31'd0, ack}, 0);
`ifdef SCCB_RESP_AUTO_INC_EN
        push_exp(1'b1, 16'h0000, 8'hBB);
        wr_byte(8'hBB, ack); chk("t6_ack_d1", {31'd0, ack}, 0);
`else
        wr_byte(8'hBB, ack); chk("t6_nack_d1", {31'd0, ack}, 1);
`endif
        stop_c();
        settle();
        chk("t6_drain", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
